mmio_uart: RTL and testbench

Memory-mapped UART peripheral that sits directly downstream of the memory map's MMIO port (0xFFFF0000–0xFFFFFFFF). It decodes the MMIO address, accepts word writes and serves word reads over the same valid/ready handshake the CPU uses, and serialises and deserialises 8N1 frames through TX and RX FIFOs. It is the first consumer of the MMIO window and gives the core console I/O.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/mmio_uart_if.sv | 17 +
 rtl/sync_fifo.sv | 43 ++++
 rtl/mmio_uart.sv | 249 ++++++++++++++++++++++++
 tb/tb_mmio_uart.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the MMIO UART: register map, STATUS bit positions and FSM state types.
package uart_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  // Word offsets selected by addr[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;

  localparam int unsigned ST_TX_FULL      = 0;
  localparam int unsigned ST_TX_EMPTY     = 1;
  localparam int unsigned ST_RX_AVAIL     = 2;
  localparam int unsigned ST_RX_OVERRUN   = 3;
  localparam int unsigned ST_RX_FRAME_ERR = 4;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {RD_IDLE, RD_RESP, RD_GAP} rd_state_e;

  function automatic logic addr_in_block(input logic [11:0] i_hi);
    return i_hi == '0;
  endfunction

endpackage

// File: rtl/mmio_uart_if.sv
// MMIO valid/ready bus between the CPU memory map (master) and the UART (slave).
interface mmio_uart_if;
  import uart_pkg::*;

  logic [31:0]           addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  rd_ready;

  modport master (output addr, wr_data, wr_valid, rd_ready,
                  input  wr_ready, rd_data, rd_valid);
  modport slave  (input  addr, wr_data, wr_valid, rd_ready,
                  output wr_ready, rd_data, rd_valid);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; pointers carry an extra wrap bit, push+pop allowed when full.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot the push lands in
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end
endmodule

// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART: register decode, read FSM, TX serialiser and RX deserialiser around two FIFOs.
module mmio_uart
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        i_clk,
  input  logic        i_rst,
  mmio_uart_if.slave  mmio,
  input  logic        i_rx,
  output logic        o_tx
);
  logic [1:0]            w_reg;
  logic                  w_hit;
  logic                  w_unused_bits;
  logic                  w_wr_fire;
  logic                  w_tx_push;
  logic                  w_tx_pop;
  logic                  w_tx_full;
  logic                  w_tx_empty;
  logic [7:0]            w_tx_dout;
  logic                  w_rx_push;
  logic                  w_rx_pop;
  logic                  w_rx_full;
  logic                  w_rx_empty;
  logic [7:0]            w_rx_dout;
  logic                  w_rx_stop_tick;
  logic                  w_rx_overrun_evt;
  logic                  w_rx_frame_evt;
  logic                  w_rd_req;
  logic                  w_status_clr;
  logic [DATA_WIDTH-1:0] w_status;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [15:0]           w_half_m1;

  logic [15:0]           r_baud;
  logic                  r_rx_overrun;
  logic                  r_rx_frame_err;
  rd_state_e             r_rd_state;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;
  tx_state_e             r_tx_state;
  logic [15:0]           r_tx_cnt;
  logic [2:0]            r_tx_bit;
  logic [7:0]            r_tx_shift;
  logic                  r_tx;
  rx_state_e             r_rx_state;
  logic [15:0]           r_rx_cnt;
  logic [2:0]            r_rx_bit;
  logic [7:0]            r_rx_shift;
  logic                  r_rx_s1;
  logic                  r_rx_s2;
  logic                  r_rx_s3;

  assign w_reg         = mmio.addr[3:2];
  assign w_hit         = addr_in_block(mmio.addr[15:4]);
  assign w_unused_bits = ^{mmio.addr[31:16], mmio.addr[1:0], mmio.wr_data[DATA_WIDTH-1:16]};

  assign mmio.wr_ready = !(w_hit && (w_reg == REG_DATA) && w_tx_full);
  assign w_wr_fire     = mmio.wr_valid && mmio.wr_ready;
  assign w_tx_push     = w_wr_fire && w_hit && (w_reg == REG_DATA);

  assign w_rd_req      = (r_rd_state == RD_IDLE) && mmio.rd_ready;
  assign w_rx_pop      = w_rd_req && w_hit && (w_reg == REG_DATA) && !w_rx_empty;
  assign w_status_clr  = w_rd_req && w_hit && (w_reg == REG_STATUS);
  assign mmio.rd_valid = r_rd_valid;
  assign mmio.rd_data  = r_rd_data;
  assign o_tx          = r_tx;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk(i_clk), .i_rst(i_rst), .i_push(w_tx_push), .i_data(mmio.wr_data[7:0]),
    .i_pop(w_tx_pop), .o_data(w_tx_dout), .o_full(w_tx_full), .o_empty(w_tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk(i_clk), .i_rst(i_rst), .i_push(w_rx_push), .i_data(r_rx_shift),
    .i_pop(w_rx_pop), .o_data(w_rx_dout), .o_full(w_rx_full), .o_empty(w_rx_empty)
  );

  always_comb begin
    w_status                  = '0;
    w_status[ST_TX_FULL]      = w_tx_full;
    w_status[ST_TX_EMPTY]     = w_tx_empty && (r_tx_state == TX_IDLE);
    w_status[ST_RX_AVAIL]     = !w_rx_empty;
    w_status[ST_RX_OVERRUN]   = r_rx_overrun;
    w_status[ST_RX_FRAME_ERR] = r_rx_frame_err;
    w_rd_word                 = '0;
    if (w_hit) begin
      case (w_reg)
        REG_DATA:   if (!w_rx_empty) w_rd_word = DATA_WIDTH'(w_rx_dout);
        REG_STATUS: w_rd_word = w_status;
        REG_BAUD:   w_rd_word = DATA_WIDTH'(r_baud);
        default:    w_rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_baud <= 16'(CLKS_PER_BIT);
    end else if (w_wr_fire && w_hit && (w_reg == REG_BAUD)) begin
      r_baud <= (mmio.wr_data[15:0] == '0) ? 16'd1 : mmio.wr_data[15:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_state <= RD_IDLE;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      case (r_rd_state)
        RD_IDLE: if (mmio.rd_ready) begin
          r_rd_data  <= w_rd_word;
          r_rd_valid <= 1'b1;
          r_rd_state <= RD_RESP;
        end
        RD_RESP: begin
          r_rd_valid <= 1'b0;
          r_rd_state <= RD_GAP;
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

  // An error arriving in the same cycle as the STATUS read survives the clear
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_overrun   <= 1'b0;
      r_rx_frame_err <= 1'b0;
    end else begin
      if (w_status_clr) begin
        r_rx_overrun   <= 1'b0;
        r_rx_frame_err <= 1'b0;
      end
      if (w_rx_overrun_evt) r_rx_overrun   <= 1'b1;
      if (w_rx_frame_evt)   r_rx_frame_err <= 1'b1;
    end
  end

  // Stop-bit expiry pops the next byte directly so consecutive frames abut
  assign w_tx_pop = !w_tx_empty &&
                    ((r_tx_state == TX_IDLE) || ((r_tx_state == TX_STOP) && (r_tx_cnt == '0)));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_state <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        TX_IDLE: if (w_tx_pop) begin
          r_tx_shift <= w_tx_dout;
          r_tx       <= 1'b0;
          r_tx_cnt   <= r_baud - 16'd1;
          r_tx_state <= TX_START;
        end
        TX_START: if (r_tx_cnt == '0) begin
          r_tx       <= r_tx_shift[0];
          r_tx_cnt   <= r_baud - 16'd1;
          r_tx_bit   <= '0;
          r_tx_state <= TX_DATA;
        end else begin
          r_tx_cnt <= r_tx_cnt - 16'd1;
        end
        TX_DATA: if (r_tx_cnt == '0) begin
          r_tx_cnt <= r_baud - 16'd1;
          if (r_tx_bit == 3'd7) begin
            r_tx       <= 1'b1;
            r_tx_state <= TX_STOP;
          end else begin
            r_tx_bit   <= r_tx_bit + 3'd1;
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx       <= r_tx_shift[1];
          end
        end else begin
          r_tx_cnt <= r_tx_cnt - 16'd1;
        end
        TX_STOP: if (r_tx_cnt == '0) begin
          if (w_tx_pop) begin
            r_tx_shift <= w_tx_dout;
            r_tx       <= 1'b0;
            r_tx_cnt   <= r_baud - 16'd1;
            r_tx_state <= TX_START;
          end else begin
            r_tx_state <= TX_IDLE;
          end
        end else begin
          r_tx_cnt <= r_tx_cnt - 16'd1;
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign w_half_m1        = (r_baud[15:1] == '0) ? '0 : ({1'b0, r_baud[15:1]} - 16'd1);
  assign w_rx_stop_tick   = (r_rx_state == RX_STOP) && (r_rx_cnt == '0);
  assign w_rx_push        = w_rx_stop_tick && r_rx_s2;
  assign w_rx_frame_evt   = w_rx_stop_tick && !r_rx_s2;
  assign w_rx_overrun_evt = w_rx_push && w_rx_full && !w_rx_pop;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_s3    <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_s1 <= i_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
      case (r_rx_state)
        RX_IDLE: if (r_rx_s3 && !r_rx_s2) begin
          r_rx_cnt   <= w_half_m1;
          r_rx_state <= RX_START;
        end
        RX_START: if (r_rx_cnt == '0) begin
          if (!r_rx_s2) begin
            r_rx_cnt   <= r_baud - 16'd1;
            r_rx_bit   <= '0;
            r_rx_state <= RX_DATA;
          end else begin
            r_rx_state <= RX_IDLE;
          end
        end else begin
          r_rx_cnt <= r_rx_cnt - 16'd1;
        end
        RX_DATA: if (r_rx_cnt == '0) begin
          r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
          r_rx_cnt   <= r_baud - 16'd1;
          if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
          else                  r_rx_bit   <= r_rx_bit + 3'd1;
        end else begin
          r_rx_cnt <= r_rx_cnt - 16'd1;
        end
        RX_STOP: if (r_rx_cnt == '0) r_rx_state <= RX_IDLE;
                 else               r_rx_cnt   <= r_rx_cnt - 16'd1;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_uart.sv
// Randomised self-checking bench for mmio_uart against a queue-based model of the UART registers and lines.
`timescale 1ns/1ps
module tb_mmio_uart;
  localparam int unsigned BAUD  = 4;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx;

  mmio_uart_if bus ();

  mmio_uart #(.FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(BAUD)) dut (
    .i_clk(clk), .i_rst(rst), .mmio(bus), .i_rx(rx), .o_tx(tx)
  );

  always #5 clk = ~clk;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state
  logic [7:0]  m_rxq[$];
  bit          m_ov = 1'b0;
  bit          m_fe = 1'b0;
  int unsigned m_baud = BAUD;
  logic [7:0]  m_txq[$];

  // Line monitor results
  bit          mon_en = 1'b0;
  logic [7:0]  mon_q[$];
  int unsigned mon_start[$];
  logic        mon_stop[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s    = '0;
    s[1] = 1'b1;
    s[2] = (m_rxq.size() != 0);
    s[3] = m_ov;
    s[4] = m_fe;
    return s;
  endfunction

  task automatic mmio_write(input logic [31:0] a, input logic [31:0] d,
                            output int unsigned waited, output int unsigned at_cyc);
    @(negedge clk);
    bus.addr = a; bus.wr_data = d; bus.wr_valid = 1'b1; waited = 0;
    #1;
    while (!bus.wr_ready && waited < 200) begin
      @(negedge clk); #1; waited++;
    end
    check("wr_accept", 32'(bus.wr_ready), 32'd1);
    @(posedge clk); #1;
    at_cyc = cyc;
    bus.wr_valid = 1'b0;
  endtask

  task automatic mmio_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.addr = a; bus.rd_ready = 1'b1;
    @(negedge clk);
    check("rd_valid_lat", 32'(bus.rd_valid), 32'd1);
    d = bus.rd_data;
    bus.rd_ready = 1'b0;
    @(negedge clk);
    check("rd_valid_pulse", 32'(bus.rd_valid), 32'd0);
    @(negedge clk);
  endtask

  task automatic read_status(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    e = m_status();
    mmio_read(32'hFFFF_0004, d);
    check(tag, d, e);
    m_ov = 1'b0; m_fe = 1'b0;
  endtask

  task automatic read_data(input string tag);
    logic [31:0] d;
    logic [31:0] e;
    e = (m_rxq.size() != 0) ? 32'(m_rxq.pop_front()) : 32'd0;
    mmio_read(32'hFFFF_0000, d);
    check(tag, d, e);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); rx = fr[i];
      repeat (BAUD - 1) @(negedge clk);
    end
    @(negedge clk); rx = 1'b1;
    repeat (2 * BAUD) @(negedge clk);
    if (!stop) m_fe = 1'b1;
    else if (m_rxq.size() < DEPTH) m_rxq.push_back(b);
    else m_ov = 1'b1;
  endtask

  // Independent UART receiver on o_tx, sampling at bit centres
  initial begin
    logic [7:0]  mb;
    int unsigned mst;
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        mst = cyc;
        repeat (m_baud / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (m_baud) @(negedge clk);
          mb[i] = tx;
        end
        repeat (m_baud) @(negedge clk);
        mon_stop.push_back(tx);
        mon_q.push_back(mb);
        mon_start.push_back(mst);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w, c, c0, lows;
    logic [7:0]  b;
    logic [9:0]  fr;
    logic [31:0] d;

    bus.addr = '0; bus.wr_data = '0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_data", bus.rd_data, 32'd0);
    rst = 1'b0;
    read_status("rst_status");
    mmio_read(32'hFFFF_0008, d);
    check("rst_baud", d, 32'(BAUD));
    read_data("rst_data_empty");

    // Single TX frame of 0x55, checked cycle by cycle
    b  = 8'h55;
    fr = {1'b1, b, 1'b0};
    mmio_write(32'hFFFF_0000, 32'(b), w, c);
    @(negedge clk);
    check("tx_before_start", 32'(tx), 32'd1);
    for (int k = 0; k < 10 * BAUD; k++) begin
      @(negedge clk);
      check($sformatf("tx55_cyc%0d", k), 32'(tx), 32'(fr[k / BAUD]));
    end
    @(negedge clk);
    check("tx55_idle", 32'(tx), 32'd1);
    read_status("tx55_status");

    // Nine back-to-back writes, tenth held until the first frame completes
    mon_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      m_txq.push_back(b);
      mmio_write(32'hFFFF_0000, {24'($urandom), b}, w, c);
      if (i == 0) c0 = c;
      if (i < 9) check($sformatf("burst_wait%0d", i), w, 32'd0);
      else       check("tenth_accept_cyc", c - c0, 32'(1 + 10 * BAUD + 1));
    end
    repeat (10 * 10 * BAUD + 20) @(negedge clk);
    check("tx_frames", mon_q.size(), 32'd10);
    for (int i = 0; i < 10 && i < mon_q.size(); i++) begin
      check($sformatf("tx_byte%0d", i), 32'(mon_q[i]), 32'(m_txq[i]));
      check($sformatf("tx_stop%0d", i), 32'(mon_stop[i]), 32'd1);
      if (i > 0) check($sformatf("tx_gap%0d", i), mon_start[i] - mon_start[i-1], 32'(10 * BAUD));
    end
    read_status("burst_status");
    mon_en = 1'b0;

    // RX: fixed 0xA3 then random bytes
    send_rx(8'hA3, 1'b1);
    read_status("rx_a3_status");
    read_data("rx_a3_data");
    read_status("rx_a3_status_after");
    for (int i = 0; i < 3; i++) begin
      send_rx(8'($urandom), 1'b1);
      read_data($sformatf("rx_rand%0d", i));
    end

    // Overrun: nine frames with no reads
    for (int i = 0; i < 9; i++) send_rx(8'($urandom), 1'b1);
    read_status("ovr_status_set");
    read_status("ovr_status_clr");
    for (int i = 0; i < 8; i++) read_data($sformatf("ovr_data%0d", i));
    read_status("ovr_drained");
    read_data("ovr_empty");

    // Framing error, then a one-cycle glitch
    send_rx(8'($urandom), 1'b0);
    read_status("ferr_status_set");
    read_status("ferr_status_clr");
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (4 * BAUD) @(negedge clk);
    read_status("glitch_status");
    read_data("glitch_data");

    // BAUD_DIV zero clamp and unmapped offsets
    mmio_write(32'hFFFF_0008, 32'd0, w, c);
    mmio_read(32'hFFFF_0008, d);
    check("baud_zero", d, 32'd1);
    mmio_write(32'hFFFF_0008, 32'(BAUD), w, c);
    mmio_read(32'hFFFF_0008, d);
    check("baud_restore", d, 32'(BAUD));
    mmio_write(32'hFFFF_0010, 32'd0, w, c);
    check("unmapped_wait", w, 32'd0);
    mmio_write(32'hFFFF_000C, 32'h1234_5678, w, c);
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("unmapped_no_tx", lows, 32'd0);
    mmio_read(32'hFFFF_000C, d);
    check("rd_0c", d, 32'd0);
    mmio_read(32'hFFFF_0014, d);
    check("rd_14", d, 32'd0);
    read_status("unmapped_status");

    // Reset in the middle of a frame with data queued in both FIFOs
    send_rx(8'($urandom), 1'b1);
    mmio_write(32'hFFFF_0000, 32'($urandom_range(0, 255)), w, c);
    mmio_write(32'hFFFF_0000, 32'($urandom_range(0, 255)), w, c);
    @(negedge clk);
    check("pre_rst_tx", 32'(tx), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", 32'(tx), 32'd1);
    rst = 1'b0;
    m_rxq.delete(); m_ov = 1'b0; m_fe = 1'b0; m_baud = BAUD;
    lows = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("post_rst_quiet", lows, 32'd0);
    read_status("post_rst_status");
    read_data("post_rst_data");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
